// File: rtl/mastermind_scorer.sv
// Mastermind scoring engine: latches a secret code, accepts guesses over a
// valid/ready handshake and scores each one in two passes (exact matches,
// then colour-only matches) so every code and guess peg is consumed at most
// once, even with repeated colours. Tracks guess count and win/loss.
module mastermind_scorer #(
    parameter int  NUM_PEGS    = 4,
    parameter int  COLOR_BITS  = 3,
    parameter int  MAX_GUESSES = 8,
    localparam int CNT_W       = $clog2(NUM_PEGS + 1),
    localparam int GC_W        = $clog2(MAX_GUESSES + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           new_game,
    input  logic                           code_we,
    input  logic [NUM_PEGS*COLOR_BITS-1:0] code_in,
    input  logic                           guess_valid,
    input  logic [NUM_PEGS*COLOR_BITS-1:0] guess_in,
    output logic                           guess_ready,
    output logic                           result_valid,
    output logic [CNT_W-1:0]               red,
    output logic [CNT_W-1:0]               white,
    output logic [GC_W-1:0]                guess_count,
    output logic                           game_won,
    output logic                           game_lost,
    output logic                           busy
);

    localparam int IDX_W = $clog2(NUM_PEGS);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_PEGS - 1);
    localparam logic [GC_W-1:0]  LAST_GUESS = GC_W'(MAX_GUESSES - 1);
    localparam logic [CNT_W-1:0] ALL_RED    = CNT_W'(NUM_PEGS);

    typedef enum logic [2:0] {
        S_WAIT_CODE,
        S_READY,
        S_RED_SCAN,
        S_WHITE_SCAN,
        S_REPORT,
        S_WON,
        S_LOST
    } state_t;

    state_t                         r_state;
    state_t                         w_state_next;
    logic [NUM_PEGS*COLOR_BITS-1:0] r_code;
    logic [NUM_PEGS*COLOR_BITS-1:0] r_guess;
    logic [NUM_PEGS-1:0]            r_code_used;
    logic [NUM_PEGS-1:0]            r_guess_used;
    logic [IDX_W-1:0]               r_idx;
    logic [CNT_W-1:0]               r_red_acc;
    logic [CNT_W-1:0]               r_white_acc;
    logic [CNT_W-1:0]               r_red;
    logic [CNT_W-1:0]               r_white;
    logic [GC_W-1:0]                r_gcount;
    logic                           r_result_valid;

    logic [COLOR_BITS-1:0]          w_code_peg  [NUM_PEGS];
    logic [COLOR_BITS-1:0]          w_guess_peg [NUM_PEGS];
    logic [NUM_PEGS-1:0]            w_idx_onehot;
    logic [NUM_PEGS-1:0]            w_color_hit;
    logic [NUM_PEGS-1:0]            w_white_first;
    logic [COLOR_BITS-1:0]          w_cur_guess;
    logic                           w_red_hit;
    logic                           w_white_hit;
    logic [IDX_W-1:0]               w_idx_next;

    // Per-peg unpacking, scan-position decode and the unused-code-peg colour matches
    generate
        for (genvar gi = 0; gi < NUM_PEGS; gi++) begin : g_peg
            assign w_code_peg[gi]   = r_code[gi*COLOR_BITS +: COLOR_BITS];
            assign w_guess_peg[gi]  = r_guess[gi*COLOR_BITS +: COLOR_BITS];
            assign w_idx_onehot[gi] = (r_idx == IDX_W'(gi));
            assign w_color_hit[gi]  = !r_code_used[gi] && (w_code_peg[gi] == w_cur_guess);
        end
    endgenerate

    assign w_cur_guess   = w_guess_peg[r_idx];
    assign w_red_hit     = (w_code_peg[r_idx] == w_cur_guess);
    // Isolate the lowest set bit: the lowest-numbered free code peg of the wanted colour
    assign w_white_first = w_color_hit & (~w_color_hit + NUM_PEGS'(1));
    assign w_white_hit   = !r_guess_used[r_idx] && (|w_color_hit);
    assign w_idx_next    = (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);

    assign guess_ready  = (r_state == S_READY);
    assign busy         = (r_state == S_RED_SCAN) || (r_state == S_WHITE_SCAN) ||
                          (r_state == S_REPORT);
    assign game_won     = (r_state == S_WON);
    assign game_lost    = (r_state == S_LOST);
    assign result_valid = r_result_valid;
    assign red          = r_red;
    assign white        = r_white;
    assign guess_count  = r_gcount;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_WAIT_CODE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; new_game overrides every other request
    always_comb begin
        w_state_next = r_state;
        if (new_game) begin
            w_state_next = S_WAIT_CODE;
        end else begin
            case (r_state)
                S_WAIT_CODE:  if (code_we)            w_state_next = S_READY;
                S_READY:      if (guess_valid)        w_state_next = S_RED_SCAN;
                S_RED_SCAN:   if (r_idx == LAST_IDX)  w_state_next = S_WHITE_SCAN;
                S_WHITE_SCAN: if (r_idx == LAST_IDX)  w_state_next = S_REPORT;
                S_REPORT: begin
                    if (r_red_acc == ALL_RED)         w_state_next = S_WON;
                    else if (r_gcount == LAST_GUESS)  w_state_next = S_LOST;
                    else                              w_state_next = S_READY;
                end
                S_WON, S_LOST:                        w_state_next = r_state;
                default:                              w_state_next = S_WAIT_CODE;
            endcase
        end
    end

    // Datapath: code/guess capture, the two scoring passes and result publication
    always_ff @(posedge clk) begin
        if (reset) begin
            r_code         <= '0;
            r_guess        <= '0;
            r_code_used    <= '0;
            r_guess_used   <= '0;
            r_idx          <= '0;
            r_red_acc      <= '0;
            r_white_acc    <= '0;
            r_red          <= '0;
            r_white        <= '0;
            r_gcount       <= '0;
            r_result_valid <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            if (new_game) begin
                r_red    <= '0;
                r_white  <= '0;
                r_gcount <= '0;
            end else begin
                case (r_state)
                    S_WAIT_CODE: begin
                        if (code_we) begin
                            r_code   <= code_in;
                            r_red    <= '0;
                            r_white  <= '0;
                            r_gcount <= '0;
                        end
                    end
                    S_READY: begin
                        if (guess_valid) begin
                            r_guess      <= guess_in;
                            r_code_used  <= '0;
                            r_guess_used <= '0;
                            r_red_acc    <= '0;
                            r_white_acc  <= '0;
                            r_idx        <= '0;
                        end
                    end
                    S_RED_SCAN: begin
                        if (w_red_hit) begin
                            r_red_acc    <= r_red_acc + CNT_W'(1);
                            r_code_used  <= r_code_used | w_idx_onehot;
                            r_guess_used <= r_guess_used | w_idx_onehot;
                        end
                        r_idx <= w_idx_next;
                    end
                    S_WHITE_SCAN: begin
                        if (w_white_hit) begin
                            r_white_acc <= r_white_acc + CNT_W'(1);
                            r_code_used <= r_code_used | w_white_first;
                        end
                        r_idx <= w_idx_next;
                    end
                    S_REPORT: begin
                        r_result_valid <= 1'b1;
                        r_red          <= r_red_acc;
                        r_white        <= r_white_acc;
                        r_gcount       <= r_gcount + GC_W'(1);
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mastermind_scorer.sv
// Bench for mastermind_scorer: stimulus pushes expected scores into a queue,
// a monitor pops and compares on every result_valid pulse.
module tb_mastermind_scorer;

    localparam int N     = 4;
    localparam int C     = 3;
    localparam int MG    = 8;
    localparam int CNT_W = $clog2(N + 1);
    localparam int GC_W  = $clog2(MG + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic             new_game;
    logic             code_we;
    logic [N*C-1:0]   code_in;
    logic             guess_valid;
    logic [N*C-1:0]   guess_in;
    logic             guess_ready;
    logic             result_valid;
    logic [CNT_W-1:0] red;
    logic [CNT_W-1:0] white;
    logic [GC_W-1:0]  guess_count;
    logic             game_won;
    logic             game_lost;
    logic             busy;

    always #5 clk = ~clk;

    mastermind_scorer #(.NUM_PEGS(N), .COLOR_BITS(C), .MAX_GUESSES(MG)) dut (
        .clk          (clk),
        .reset        (reset),
        .new_game     (new_game),
        .code_we      (code_we),
        .code_in      (code_in),
        .guess_valid  (guess_valid),
        .guess_in     (guess_in),
        .guess_ready  (guess_ready),
        .result_valid (result_valid),
        .red          (red),
        .white        (white),
        .guess_count  (guess_count),
        .game_won     (game_won),
        .game_lost    (game_lost),
        .busy         (busy)
    );

    typedef struct {
        int red;
        int white;
        int gc;
        int won;
        int lost;
        int acc;
    } exp_t;

    exp_t           exp_q[$];
    int             n_tests = 0;
    int             n_fail  = 0;
    int             cyc     = 0;
    logic [N*C-1:0] m_code;
    int             m_gc;
    bit             m_done;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reference score: red = positional matches; red+white = sum over colours
    // of min(occurrences in code, occurrences in guess).
    task automatic score(input logic [N*C-1:0] code, input logic [N*C-1:0] guess,
                         output int r, output int w);
        int cc[1<<C];
        int gcn[1<<C];
        int a;
        int b;
        for (int k = 0; k < (1 << C); k++) begin
            cc[k]  = 0;
            gcn[k] = 0;
        end
        r = 0;
        for (int i = 0; i < N; i++) begin
            a = int'(code[i*C +: C]);
            b = int'(guess[i*C +: C]);
            if (a == b) r++;
            cc[a]++;
            gcn[b]++;
        end
        w = 0;
        for (int k = 0; k < (1 << C); k++) w += (cc[k] < gcn[k]) ? cc[k] : gcn[k];
        w -= r;
    endtask

    function automatic logic [N*C-1:0] rand_code(input int cmax);
        logic [N*C-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i*C +: C] = C'($urandom_range(0, cmax));
        return v;
    endfunction

    // Monitor: one scoreboard pop and compare per result pulse
    always @(negedge clk) begin
        exp_t e;
        if (!reset && result_valid) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_result: got red=%0d white=%0d, expected no result",
                         red, white);
            end else begin
                e = exp_q.pop_front();
                $display("[TB] result: red=%0d white=%0d count=%0d won=%0d lost=%0d (exp %0d/%0d)",
                         red, white, guess_count, game_won, game_lost, e.red, e.white);
                chk("red", int'(red), e.red);
                chk("white", int'(white), e.white);
                chk("guess_count", int'(guess_count), e.gc);
                chk("game_won", int'(game_won), e.won);
                chk("game_lost", int'(game_lost), e.lost);
                chk("latency", cyc - e.acc, 2*N + 1);
                chk("ready_after_result", int'(guess_ready), (e.won | e.lost) ? 0 : 1);
                chk("busy_after_result", int'(busy), 0);
            end
        end
    end

    // Called at a negedge; waits (bounded) for ready, records the expected score
    task automatic send_guess(input logic [N*C-1:0] g);
        exp_t e;
        int   r;
        int   w;
        bit   ok = 1'b0;
        guess_valid = 1'b1;
        guess_in    = g;
        for (int i = 0; i < 100; i++) begin
            if (guess_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            chk("accept_timeout", 0, 1);
            guess_valid = 1'b0;
            return;
        end
        score(m_code, g, r, w);
        m_gc++;
        e.red   = r;
        e.white = w;
        e.gc    = m_gc;
        e.won   = (r == N) ? 1 : 0;
        e.lost  = (r != N && m_gc == MG) ? 1 : 0;
        e.acc   = cyc + 1;
        exp_q.push_back(e);
        m_done = (e.won != 0) || (e.lost != 0);
        @(negedge clk);
        guess_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic start_game(input logic [N*C-1:0] code);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        code_we  = 1'b1;
        code_in  = code;
        @(negedge clk);
        code_we  = 1'b0;
        m_code   = code;
        m_gc     = 0;
        m_done   = 1'b0;
        chk("load_ready", int'(guess_ready), 1);
        chk("load_count", int'(guess_count), 0);
    endtask

    initial begin
        int rc;
        logic [N*C-1:0] g;
        reset       = 1'b1;
        new_game    = 1'b0;
        code_we     = 1'b0;
        code_in     = '0;
        guess_valid = 1'b0;
        guess_in    = '0;
        m_code      = '0;
        m_gc        = 0;
        m_done      = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_red", int'(red), 0);
        chk("rst_white", int'(white), 0);
        chk("rst_count", int'(guess_count), 0);
        chk("rst_valid", int'(result_valid), 0);
        chk("rst_won", int'(game_won), 0);
        chk("rst_lost", int'(game_lost), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(guess_ready), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("wait_code_ready", int'(guess_ready), 0);

        // Exact win on the first guess
        start_game({3'd4, 3'd3, 3'd2, 3'd1});
        send_guess({3'd4, 3'd3, 3'd2, 3'd1});
        wait_drain();
        chk("won_level", int'(game_won), 1);

        // All colour-only matches, then a code write in READY must be ignored
        start_game({3'd2, 3'd2, 3'd1, 3'd1});
        send_guess({3'd1, 3'd1, 3'd2, 3'd2});
        wait_drain();
        chk("back_to_ready", int'(guess_ready), 1);
        code_we = 1'b1;
        code_in = {3'd5, 3'd6, 3'd7, 3'd0};
        @(negedge clk);
        code_we = 1'b0;
        chk("ready_after_code_we", int'(guess_ready), 1);
        send_guess({3'd1, 3'd1, 3'd2, 3'd2});
        wait_drain();

        // Duplicate colours must not be double counted
        start_game({3'd3, 3'd2, 3'd1, 3'd1});
        send_guess({3'd1, 3'd1, 3'd2, 3'd1});
        send_guess({3'd1, 3'd3, 3'd1, 3'd2});
        wait_drain();

        // Loss after MAX_GUESSES misses; held guess_valid is never accepted
        start_game('0);
        for (int i = 0; i < MG; i++) send_guess({N{3'd7}});
        wait_drain();
        guess_valid = 1'b1;
        guess_in    = '0;
        rc = 0;
        repeat (10) begin
            @(negedge clk);
            rc += int'(guess_ready);
        end
        guess_valid = 1'b0;
        chk("lost_hold_ready", rc, 0);
        chk("lost_level", int'(game_lost), 1);
        chk("lost_count", int'(guess_count), MG);

        // Abort during the white pass; the simultaneous code write is dropped
        start_game({3'd4, 3'd3, 3'd2, 3'd1});
        send_guess('0);
        wait_drain();
        send_guess({3'd1, 3'd2, 3'd3, 3'd4});
        repeat (4) @(negedge clk);
        chk("abort_busy", int'(busy), 1);
        new_game = 1'b1;
        code_we  = 1'b1;
        code_in  = {3'd6, 3'd6, 3'd6, 3'd6};
        exp_q.delete();
        @(negedge clk);
        new_game = 1'b0;
        code_we  = 1'b0;
        chk("abort_red", int'(red), 0);
        chk("abort_white", int'(white), 0);
        chk("abort_count", int'(guess_count), 0);
        chk("abort_ready", int'(guess_ready), 0);
        chk("abort_busy_clr", int'(busy), 0);
        repeat (12) @(negedge clk);
        chk("abort_stays_wait", int'(guess_ready), 0);

        // Randomised games, alternating narrow and full colour ranges
        for (int gm = 0; gm < 8; gm++) begin
            start_game(rand_code((gm % 2) ? 3 : 7));
            while (!m_done) begin
                g = ($urandom_range(0, 5) == 0) ? m_code : rand_code((gm % 2) ? 3 : 7);
                send_guess(g);
            end
            wait_drain();
        end

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
